// File: rtl/dcache_pkg.sv
// Shared configuration, FSM state type and address-field helper for the data cache.
package dcache_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned ADDRESS_WIDTH  = 32;
  localparam int unsigned INDEX_WIDTH    = 6;
  localparam int unsigned OFFSET_WIDTH   = 2;

  localparam int unsigned WORDS_PER_LINE = 1 << OFFSET_WIDTH;
  localparam int unsigned NUM_SETS       = 1 << INDEX_WIDTH;
  localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8;
  localparam int unsigned TAG_WIDTH      = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2;
  // Line base address without the offset and byte bits: {tag, index}.
  localparam int unsigned LINE_WIDTH     = TAG_WIDTH + INDEX_WIDTH;

  typedef enum logic {IDLE, REFILL} dcache_state_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] word;
  } addr_fields_t;

  // Takes the word address (byte bits already dropped).
  function automatic addr_fields_t split_addr(input logic [ADDRESS_WIDTH-3:0] word_addr);
    addr_fields_t f;
    f.word  = word_addr[OFFSET_WIDTH-1:0];
    f.index = word_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    f.tag   = word_addr[ADDRESS_WIDTH-3 -: TAG_WIDTH];
    return f;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// M-stage pipeline signals plus the refill beat port of the data cache.
interface dcache_ctrl_if;
  import dcache_pkg::*;

  logic                     MemReadM;
  logic                     MemWriteM;
  logic [ADDRESS_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0]    WriteDataM;
  logic [BE_WIDTH-1:0]      ByteEnM;
  logic [DATA_WIDTH-1:0]    ReadDataM;
  logic                     HitM;
  logic                     mem_req;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_ready;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  // Pipeline and memory side.
  modport master (
    output MemReadM, MemWriteM, ALUResultM, WriteDataM, ByteEnM, mem_ready, mem_rdata,
    input  ReadDataM, HitM, mem_req, mem_addr
  );

  // Cache controller side.
  modport slave (
    input  MemReadM, MemWriteM, ALUResultM, WriteDataM, ByteEnM, mem_ready, mem_rdata,
    output ReadDataM, HitM, mem_req, mem_addr
  );

endinterface

// File: rtl/dcache_array.sv
// Tag, valid and data storage: combinational read, synchronous writes, async valid clear.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INDEX_WIDTH-1:0]  rd_index,
  input  logic [OFFSET_WIDTH-1:0] rd_word,
  output logic [TAG_WIDTH-1:0]    rd_tag,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    wr_en,
  input  logic [INDEX_WIDTH-1:0]  wr_index,
  input  logic [OFFSET_WIDTH-1:0] wr_word,
  input  logic [BE_WIDTH-1:0]     wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    tag_we,
  input  logic [INDEX_WIDTH-1:0]  tag_index,
  input  logic [TAG_WIDTH-1:0]    tag_wdata
);

  logic [DATA_WIDTH-1:0] data_q [NUM_SETS][WORDS_PER_LINE];
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0]   valid_q;

  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

  // Tag and data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wr_be[b]) data_q[wr_index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (tag_we) tag_q[tag_index] <= tag_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[tag_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller with beat-wise refill.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  dcache_ctrl_if.slave bus
);

  dcache_state_t           state_q, state_d;
  logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
  logic [LINE_WIDTH-1:0]   base_q, base_d;

  addr_fields_t            f;
  logic [TAG_WIDTH-1:0]    rd_tag;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    hit_raw;
  logic                    hit;
  logic                    req;
  logic [ADDRESS_WIDTH-1:0] addr;

  logic                    dwr_en;
  logic [INDEX_WIDTH-1:0]  dwr_index;
  logic [OFFSET_WIDTH-1:0] dwr_word;
  logic [BE_WIDTH-1:0]     dwr_be;
  logic [DATA_WIDTH-1:0]   dwr_data;
  logic                    tag_we;

  assign f       = split_addr(bus.ALUResultM[ADDRESS_WIDTH-1:2]);
  assign hit_raw = rd_valid && (rd_tag == f.tag);

  dcache_array u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_index  (f.index),
    .rd_word   (f.word),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_en     (dwr_en),
    .wr_index  (dwr_index),
    .wr_word   (dwr_word),
    .wr_be     (dwr_be),
    .wr_data   (dwr_data),
    .tag_we    (tag_we),
    .tag_index (base_q[INDEX_WIDTH-1:0]),
    .tag_wdata (base_q[LINE_WIDTH-1:INDEX_WIDTH])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    hit       = 1'b1;
    req       = 1'b0;
    addr      = '0;
    dwr_en    = 1'b0;
    dwr_index = f.index;
    dwr_word  = f.word;
    dwr_be    = bus.ByteEnM;
    dwr_data  = bus.WriteDataM;
    tag_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A load wins over a simultaneous store.
        if (bus.MemReadM) begin
          hit = hit_raw;
          if (!hit_raw) begin
            state_d = REFILL;
            beat_d  = '0;
            base_d  = bus.ALUResultM[ADDRESS_WIDTH-1:OFFSET_WIDTH+2];
          end
        end else if (bus.MemWriteM && hit_raw) begin
          dwr_en = 1'b1;
        end
      end
      REFILL: begin
        hit       = 1'b0;
        req       = 1'b1;
        addr      = {base_q, beat_q, 2'b00};
        dwr_index = base_q[INDEX_WIDTH-1:0];
        dwr_word  = beat_q;
        dwr_be    = '1;
        dwr_data  = bus.mem_rdata;
        if (bus.mem_ready) begin
          dwr_en = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == OFFSET_WIDTH'(WORDS_PER_LINE - 1)) begin
            tag_we  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.HitM      = hit;
  assign bus.mem_req   = req;
  assign bus.mem_addr  = addr;
  assign bus.ReadDataM = rd_valid ? rd_data : '0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: vector tables for single-cycle accesses, sequences for refills.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) begin
    if (rst_n) assert (!(bus.MemReadM && bus.MemWriteM)) else $error("illegal load+store together");
  end

  // Backing memory contents as seen by refills.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return 32'hC000_0000 ^ a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.MemReadM   = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.WriteDataM = '0;
    bus.ByteEnM    = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic add_vec(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic exp_hit, input logic [31:0] exp_data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_hit = exp_hit; v.exp_data = exp_data;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.MemReadM   = vecs[i].rd;
      bus.MemWriteM  = vecs[i].wr;
      bus.ALUResultM = vecs[i].addr;
      bus.WriteDataM = vecs[i].wdata;
      bus.ByteEnM    = vecs[i].be;
      #1;
      check($sformatf("%s[%0d] hit", tag, i), 32'(bus.HitM), 32'(vecs[i].exp_hit));
      check($sformatf("%s[%0d] req", tag, i), 32'(bus.mem_req), 32'd0);
      if (vecs[i].rd) check($sformatf("%s[%0d] data", tag, i), bus.ReadDataM, vecs[i].exp_data);
    end
    @(negedge clk);
    idle_inputs();
    vecs.delete();
  endtask

  // Load that may miss; alt = 1 holds mem_ready low on alternate refill cycles.
  task automatic do_load(input string name, input logic [31:0] a, input logic [31:0] exp_data,
                         input bit alt, input int exp_stalls);
    logic [31:0] base;
    int          stalls;
    int          beat;
    int          cyc;
    bit          phase;
    base   = a & ~32'hF;
    stalls = 0;
    beat   = 0;
    cyc    = 0;
    phase  = !alt;
    @(negedge clk);
    bus.MemReadM   = 1'b1;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = a;
    bus.mem_ready  = 1'b0;
    #1;
    while (bus.HitM !== 1'b1 && cyc < 40) begin
      stalls++;
      if (cyc == 0) begin
        check({name, " req idle"}, 32'(bus.mem_req), 32'd0);
      end else begin
        check({name, " req"}, 32'(bus.mem_req), 32'd1);
        check({name, " addr"}, bus.mem_addr, base + 32'(beat * 4));
        bus.mem_ready = alt ? phase : 1'b1;
        bus.mem_rdata = mem_word(base + 32'(beat * 4));
        if (bus.mem_ready) beat++;
        phase = !phase;
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      cyc++;
    end
    check({name, " stalls"}, 32'(stalls), 32'(exp_stalls));
    check({name, " beats"}, 32'(beat), (exp_stalls == 0) ? 32'd0 : 32'd4);
    check({name, " hit"}, 32'(bus.HitM), 32'd1);
    check({name, " data"}, bus.ReadDataM, exp_data);
    check({name, " req done"}, 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bus.ALUResultM = '0;
    #12;
    check("reset hit", 32'(bus.HitM), 32'd1);
    check("reset req", 32'(bus.mem_req), 32'd0);
    check("reset addr", bus.mem_addr, 32'd0);
    check("reset rdata", bus.ReadDataM, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_load("cold 104", 32'h0000_0104, 32'h22, 1'b0, 5);

    add_vec(1, 0, 32'h10C, 32'h0, 4'h0, 1'b1, 32'h44);
    add_vec(1, 0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h11);
    add_vec(0, 1, 32'h104, 32'h0000_AB00, 4'b0010, 1'b1, 32'h0);
    add_vec(1, 0, 32'h104, 32'h0, 4'h0, 1'b1, 32'h0000_AB22);
    add_vec(0, 1, 32'h300, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0);
    add_vec(0, 1, 32'h1108, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    add_vec(1, 0, 32'h108, 32'h0, 4'h0, 1'b1, 32'h33);
    add_vec(1, 0, 32'h10C, 32'h0, 4'h0, 1'b1, 32'h44);
    run_vecs("warm");

    do_load("store miss 300", 32'h300, mem_word(32'h300), 1'b0, 5);
    do_load("backpressure 208", 32'h208, mem_word(32'h208), 1'b1, 9);

    add_vec(1, 0, 32'h200, 32'h0, 4'h0, 1'b1, mem_word(32'h200));
    add_vec(1, 0, 32'h204, 32'h0, 4'h0, 1'b1, mem_word(32'h204));
    add_vec(1, 0, 32'h20C, 32'h0, 4'h0, 1'b1, mem_word(32'h20C));
    add_vec(1, 0, 32'h104, 32'h0, 4'h0, 1'b1, 32'h0000_AB22);
    run_vecs("bp");

    do_load("conflict 1104", 32'h1104, mem_word(32'h1104), 1'b0, 5);
    do_load("refetch 104", 32'h104, 32'h22, 1'b0, 5);
    do_load("hit 104", 32'h104, 32'h22, 1'b0, 0);

    // Abort a refill of line 0x400 once two beats have landed.
    @(negedge clk);
    bus.MemReadM   = 1'b1;
    bus.ALUResultM = 32'h404;
    #1;
    check("abort miss", 32'(bus.HitM), 32'd0);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      #1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = mem_word(32'h400 + 32'(b * 4));
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("abort pre addr", bus.mem_addr, 32'h408);
    rst_n = 1'b0;
    #1;
    check("abort req", 32'(bus.mem_req), 32'd0);
    check("abort addr", bus.mem_addr, 32'd0);
    bus.MemReadM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_load("post abort 404", 32'h404, mem_word(32'h404), 1'b0, 5);
    do_load("post reset 104", 32'h104, 32'h22, 1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
